// File: rtl/motor_pwm_if.sv
// motor_pwm_if: groups the switch/comparator inputs and the bridge/display
// outputs of motor_pwm_ctrl. The controller connects through the slave
// modport; whatever drives the switches (board top or bench) uses master.
interface motor_pwm_if;
  logic [3:0] sw_speed;
  logic [3:0] sw_dir;
  logic       comp_a;
  logic       comp_b;
  logic       ena;
  logic       enb;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       in4;
  logic       fault;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;

  modport master (
    output sw_speed, sw_dir, comp_a, comp_b,
    input  ena, enb, in1, in2, in3, in4, fault, dig0, dig1, dig2, dig3
  );

  modport slave (
    input  sw_speed, sw_dir, comp_a, comp_b,
    output ena, enb, in1, in2, in3, in4, fault, dig0, dig1, dig2, dig3
  );
endinterface

// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl: two-motor H-bridge controller.
// - Switches and overcurrent comparators are 2-flop synchronized; switches
//   are additionally debounced per bit.
// - Speed (25/50/75/100 %) and direction are priority-encoded from the
//   debounced switches; a free-running PWM counter gates ena/enb in RUN.
// - A direction change while running inserts a dead time with the bridge off.
// - Any comparator hit forces FAULT, which is held for a cooldown and left
//   only once the comparators are quiet and the speed switches are at 0 %.
// Build option: define SOFT_START_EN to ramp the duty up by one quarter per
// PWM period instead of jumping straight to the target at the next wrap.
module motor_pwm_ctrl #(
  parameter int PWM_PERIOD      = 1000,     // multiple of 4
  parameter int DEB_CYCLES      = 65536,
  parameter int DEAD_CYCLES     = 5000,
  parameter int COOLDOWN_CYCLES = 10000000
) (
  input  logic       clock,
  input  logic       resetn,
  motor_pwm_if.slave bus
);

  localparam int CW      = $clog2(PWM_PERIOD + 1);
  localparam int DW      = $clog2(DEB_CYCLES + 1);
  localparam int TW      = $clog2(DEAD_CYCLES + 1);
  localparam int FW      = $clog2(COOLDOWN_CYCLES + 1);
  localparam int QUARTER = PWM_PERIOD / 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DEAD,
    S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    D_STOP,
    D_FWD,
    D_BWD,
    D_LEFT,
    D_RIGHT
  } dir_t;

  // ---------------------------------------------------------------------------
  // Input synchronization: {comp_b, comp_a, sw_dir, sw_speed}
  // ---------------------------------------------------------------------------
  logic [9:0] sync1;
  logic [9:0] sync2;
  logic [7:0] sw_sync;
  logic       comp_hit;

  // Two-flop synchronizer for every asynchronous input.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, which
      // is what builds the second flop; a blocking '=' would collapse the
      // chain into a single stage.
      sync1 <= {bus.comp_b, bus.comp_a, bus.sw_dir, bus.sw_speed};
      sync2 <= sync1;
    end
  end

  assign sw_sync  = sync2[7:0];
  assign comp_hit = sync2[9] | sync2[8];

  // ---------------------------------------------------------------------------
  // Per-switch debounce: a bit is accepted once it has differed from the
  // debounced value for DEB_CYCLES consecutive cycles.
  // ---------------------------------------------------------------------------
  logic [7:0]    sw_deb;
  logic [DW-1:0] deb_cnt [8];

  // Debounce counters and accepted switch values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_deb <= '0;
      // NOTE: the counter array is only eight registers, so it is reset like
      // any other state; a glitch straight after reset must not be able to
      // inherit a stale count.
      for (int i = 0; i < 8; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sw_sync[i] == sw_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          sw_deb[i]  <= sw_sync[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Speed / direction decode
  // ---------------------------------------------------------------------------
  logic [3:0] spd_deb;
  logic [3:0] dir_deb;
  logic [2:0] target_k;   // duty in quarters of a period, 0..4
  dir_t       dir_cur;
  logic       go;

  assign spd_deb = sw_deb[3:0];
  assign dir_deb = sw_deb[7:4];

  // Priority encoders: lowest speed bit wins, highest direction bit wins.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    target_k = 3'd0;
    dir_cur  = D_STOP;
    if      (spd_deb[0]) target_k = 3'd1;
    else if (spd_deb[1]) target_k = 3'd2;
    else if (spd_deb[2]) target_k = 3'd3;
    else if (spd_deb[3]) target_k = 3'd4;
    if      (dir_deb[3]) dir_cur = D_RIGHT;
    else if (dir_deb[2]) dir_cur = D_LEFT;
    else if (dir_deb[1]) dir_cur = D_BWD;
    else if (dir_deb[0]) dir_cur = D_FWD;
  end

  assign go = (dir_cur != D_STOP) && (target_k != 3'd0);

  // ---------------------------------------------------------------------------
  // PWM counter and duty register
  // ---------------------------------------------------------------------------
  logic [CW-1:0] pwm_cnt;
  logic          pwm_wrap;
  logic [2:0]    duty_k;
  logic [CW-1:0] duty_cycles;

  assign pwm_wrap = (pwm_cnt == CW'(PWM_PERIOD - 1));

  // Free-running period counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)       pwm_cnt <= '0;
    else if (pwm_wrap) pwm_cnt <= '0;
    else               pwm_cnt <= pwm_cnt + CW'(1);
  end

  // Duty only changes at the period boundary so no pulse is ever truncated.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      duty_k <= 3'd0;
    end else if (pwm_wrap) begin
`ifdef SOFT_START_EN
      if (duty_k < target_k) duty_k <= duty_k + 3'd1;
      else                   duty_k <= target_k;
`else
      duty_k <= target_k;
`endif
    end
  end

  // Quarter count to clock cycles.
  always_comb begin
    duty_cycles = '0;
    case (duty_k)
      3'd1:    duty_cycles = CW'(QUARTER);
      3'd2:    duty_cycles = CW'(2 * QUARTER);
      3'd3:    duty_cycles = CW'(3 * QUARTER);
      3'd4:    duty_cycles = CW'(PWM_PERIOD);
      default: duty_cycles = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  state_t        state_nxt;
  dir_t          run_dir;    // direction actually applied to the bridge
  logic [TW-1:0] dead_cnt;
  logic [FW-1:0] cool_cnt;
  logic          dead_done;
  logic          cool_done;

  assign dead_done = (dead_cnt == TW'(DEAD_CYCLES - 1));
  assign cool_done = (cool_cnt == FW'(COOLDOWN_CYCLES - 1));

  // Next-state logic; a comparator hit overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (comp_hit) begin
      state_nxt = S_FAULT;
    end else begin
      case (state)
        S_IDLE:  if (go) state_nxt = S_RUN;
        S_RUN: begin
          if (!go)                       state_nxt = S_IDLE;
          else if (dir_cur != run_dir)   state_nxt = S_DEAD;
        end
        S_DEAD:  if (dead_done) state_nxt = go ? S_RUN : S_IDLE;
        S_FAULT: if (cool_done && target_k == 3'd0) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register plus dead-time and cooldown counters.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      run_dir  <= D_STOP;
      dead_cnt <= '0;
      cool_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Latch the direction on entry to RUN; a later change is what
      // triggers the dead time.
      if (state_nxt == S_RUN && state != S_RUN) run_dir <= dir_cur;
      if (state == S_DEAD && state_nxt == S_DEAD) dead_cnt <= dead_cnt + TW'(1);
      else                                        dead_cnt <= '0;
      // Cooldown restarts on entry and on every comparator re-assertion,
      // then saturates until the exit conditions are met.
      if (state != S_FAULT || comp_hit) cool_cnt <= '0;
      else if (!cool_done)              cool_cnt <= cool_cnt + FW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic       pwm_on;
  logic [3:0] bridge;    // {in1, in2, in3, in4}

  assign pwm_on = (pwm_cnt < duty_cycles);

  // Bridge, enable, fault and display decode from the registered state.
  always_comb begin
    bridge   = 4'b0000;
    bus.ena  = 1'b0;
    bus.enb  = 1'b0;
    bus.fault = 1'b0;
    bus.dig0 = 4'd15;
    bus.dig1 = 4'd0;
    bus.dig2 = 4'd0;
    bus.dig3 = 4'd0;

    case (dir_cur)
      D_FWD:   bus.dig0 = 4'd11;
      D_BWD:   bus.dig0 = 4'd10;
      D_LEFT:  bus.dig0 = 4'd12;
      D_RIGHT: bus.dig0 = 4'd13;
      default: bus.dig0 = 4'd15;
    endcase

    case (target_k)
      3'd1:    {bus.dig3, bus.dig2, bus.dig1} = {4'd0, 4'd2, 4'd5};
      3'd2:    {bus.dig3, bus.dig2, bus.dig1} = {4'd0, 4'd5, 4'd0};
      3'd3:    {bus.dig3, bus.dig2, bus.dig1} = {4'd0, 4'd7, 4'd5};
      3'd4:    {bus.dig3, bus.dig2, bus.dig1} = {4'd1, 4'd0, 4'd0};
      default: {bus.dig3, bus.dig2, bus.dig1} = {4'd0, 4'd0, 4'd0};
    endcase

    if (state == S_RUN) begin
      bus.ena = pwm_on;
      bus.enb = pwm_on;
      case (run_dir)
        D_FWD:   bridge = 4'b1010;
        D_BWD:   bridge = 4'b0101;
        D_LEFT:  bridge = 4'b0110;
        D_RIGHT: bridge = 4'b1001;
        default: bridge = 4'b0000;
      endcase
    end

    if (state == S_FAULT) begin
      bus.fault = 1'b1;
      bus.dig0  = 4'd11;
      bus.dig1  = 4'd11;
      bus.dig2  = 4'd11;
      bus.dig3  = 4'd11;
    end

    {bus.in1, bus.in2, bus.in3, bus.in4} = bridge;
  end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// tb_motor_pwm_ctrl: scenario bench for motor_pwm_ctrl with short timing
// parameters; expectations come from a behavioural model of the switch,
// duty and display rules.
module tb_motor_pwm_ctrl;

  localparam int PERIOD = 100;
  localparam int DEB    = 4;
  localparam int DEAD   = 8;
  localparam int COOL   = 50;

  logic clock;
  logic resetn;
  int   checks;
  int   errors;

  motor_pwm_if bus ();

  motor_pwm_ctrl #(
    .PWM_PERIOD      (PERIOD),
    .DEB_CYCLES      (DEB),
    .DEAD_CYCLES     (DEAD),
    .COOLDOWN_CYCLES (COOL)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Speed in percent: lowest set bit wins, 25 % per step.
  function automatic int model_pct(logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return 25 * (i + 1);
    return 0;
  endfunction

  // Direction: 0 stop, 1 forward, 2 backward, 3 left, 4 right; highest bit wins.
  function automatic int model_dir(logic [3:0] d);
    for (int i = 3; i >= 0; i--) if (d[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [3:0] model_bridge(int d);
    case (d)
      1:       return 4'b1010;
      2:       return 4'b0101;
      3:       return 4'b0110;
      4:       return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] model_dig0(int d);
    case (d)
      1:       return 4'd11;
      2:       return 4'd10;
      3:       return 4'd12;
      4:       return 4'd13;
      default: return 4'd15;
    endcase
  endfunction

  // Percent shown as hundreds/tens/units digits {dig3, dig2, dig1}.
  function automatic logic [11:0] model_digits(int pct);
    logic [3:0] h, t, u;
    h = 4'(pct / 100);
    t = 4'((pct / 10) % 10);
    u = 4'(pct % 10);
    return {h, t, u};
  endfunction

  // Enabled cycles in period p (0-based) after the target jumps from 0 % to pct.
  function automatic int model_ramp(int p, int pct);
`ifdef SOFT_START_EN
    int q;
    q = (p + 1) * 25;
    if (q > pct) q = pct;
    return PERIOD * q / 100;
`else
    return PERIOD * pct / 100 + 0 * p;
`endif
  endfunction

  function automatic logic [3:0] bridge_now();
    return {bus.in1, bus.in2, bus.in3, bus.in4};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Counts ena-high cycles over n cycles; flags any ena/enb disagreement
  // and any bridge/display deviation from the given expectation.
  task automatic measure(input int n, input logic [3:0] exp_br, input logic [3:0] exp_d0,
                         input logic [11:0] exp_dg, output int highs, output int bad);
    highs = 0;
    bad   = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.ena) highs++;
      if (bus.ena !== bus.enb || bridge_now() !== exp_br || bus.dig0 !== exp_d0 ||
          {bus.dig3, bus.dig2, bus.dig1} !== exp_dg || bus.fault !== 1'b0) bad++;
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    resetn = 1'b0;
    wait_cycles(3);
    checks++;
    if ({bus.ena, bus.enb, bridge_now(), bus.fault} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ena/enb/in/fault=%b expected 0000000",
               {bus.ena, bus.enb, bridge_now(), bus.fault});
    end
    checks++;
    if ({bus.dig0, bus.dig1, bus.dig2, bus.dig3} !== {4'd15, 4'd0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_digits: got %0d %0d %0d %0d expected 15 0 0 0",
               bus.dig0, bus.dig1, bus.dig2, bus.dig3);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_run_forward();
    int highs, bad;
    bus.sw_dir   = 4'b0001;
    bus.sw_speed = 4'b0010;
    wait_cycles(250);
    measure(300, model_bridge(1), model_dig0(1), model_digits(50), highs, bad);
    checks++;
    if (highs !== 3 * PERIOD * 50 / 100) begin
      errors++;
      $display("FAIL fwd50_duty: got %0d high cycles in 300 expected %0d", highs, 3 * PERIOD / 2);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL fwd50_outputs: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_priority_glitch();
    int highs, bad;
    logic [3:0] exp_br;
    bus.sw_speed = 4'b1001;
    wait_cycles(250);
    measure(200, model_bridge(1), model_dig0(1), model_digits(model_pct(4'b1001)), highs, bad);
    checks++;
    if (highs !== 2 * PERIOD / 4 || bad !== 0) begin
      errors++;
      $display("FAIL prio25: got highs=%0d bad=%0d expected highs=%0d bad=0", highs, bad, PERIOD / 2);
    end
    // 3-cycle glitch on both switch groups must be filtered out.
    bus.sw_speed = 4'b0100;
    bus.sw_dir   = 4'b1000;
    wait_cycles(3);
    bus.sw_speed = 4'b1001;
    bus.sw_dir   = 4'b0001;
    exp_br = model_bridge(1);
    measure(200, exp_br, model_dig0(1), model_digits(25), highs, bad);
    checks++;
    if (highs !== 2 * PERIOD / 4 || bad !== 0) begin
      errors++;
      $display("FAIL glitch_filter: got highs=%0d bad=%0d expected highs=%0d bad=0", highs, bad, PERIOD / 2);
    end
  endtask

  task automatic test_dead_time();
    int zeros, en_in_dead;
    logic [3:0] after;
    logic seen_after;
    zeros = 0;
    en_in_dead = 0;
    after = 4'b0000;
    seen_after = 1'b0;
    bus.sw_dir = 4'b1000;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!seen_after) begin
        if (bridge_now() === 4'b0000) begin
          zeros++;
          if (bus.ena || bus.enb) en_in_dead++;
        end else if (zeros > 0) begin
          after = bridge_now();
          seen_after = 1'b1;
        end
      end
    end
    checks++;
    if (zeros !== DEAD || en_in_dead !== 0) begin
      errors++;
      $display("FAIL dead_len: got %0d off cycles (%0d with enable) expected %0d (0)",
               zeros, en_in_dead, DEAD);
    end
    checks++;
    if (after !== model_bridge(model_dir(4'b1000))) begin
      errors++;
      $display("FAIL dead_newdir: got %b expected %b", after, model_bridge(4));
    end
  endtask

  task automatic test_fault_hold_speed();
    int lat;
    lat = -1;
    bus.comp_b = 1'b1;
    tick();
    bus.comp_b = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (lat < 0 && bus.fault === 1'b1) lat = i;
      if (lat < 0) tick();
    end
    checks++;
    if (lat < 1 || lat > 3) begin
      errors++;
      $display("FAIL fault_latency: got %0d cycles expected 1..3", lat);
    end
    checks++;
    if ({bus.dig0, bus.dig1, bus.dig2, bus.dig3} !== {4'd11, 4'd11, 4'd11, 4'd11} ||
        {bus.ena, bus.enb, bridge_now()} !== 6'd0) begin
      errors++;
      $display("FAIL fault_outputs: got dig=%0d %0d %0d %0d en/in=%b expected 11 11 11 11 000000",
               bus.dig0, bus.dig1, bus.dig2, bus.dig3, {bus.ena, bus.enb, bridge_now()});
    end
    wait_cycles(3 * COOL);
    checks++;
    if (bus.fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_hold: got fault=%b expected 1 with speed nonzero", bus.fault);
    end
    bus.sw_speed = 4'b0000;
    wait_cycles(2 + DEB + 5);
    checks++;
    if (bus.fault !== 1'b0 || bridge_now() !== 4'b0000 || bus.dig0 !== model_dig0(4) ||
        {bus.dig3, bus.dig2, bus.dig1} !== model_digits(0)) begin
      errors++;
      $display("FAIL fault_exit: got fault=%b in=%b dig0=%0d expected 0 0000 %0d",
               bus.fault, bridge_now(), bus.dig0, model_dig0(4));
    end
  endtask

  task automatic test_fault_cooldown();
    int first, count;
    first = -1;
    count = 0;
    // Pulse comp_a before edge 0 and comp_b before edge 20; the cooldown
    // restarts at the second pulse, so fault lasts 20 + COOL cycles.
    for (int i = 0; i < 160; i++) begin
      bus.comp_a = (i == 0);
      bus.comp_b = (i == 20);
      tick();
      if (bus.fault === 1'b1) begin
        count++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (first !== 2) begin
      errors++;
      $display("FAIL cool_entry: got first fault at edge %0d expected 2", first);
    end
    checks++;
    if (count !== 20 + COOL) begin
      errors++;
      $display("FAIL cool_restart: got %0d fault cycles expected %0d", count, 20 + COOL);
    end
  endtask

  task automatic test_duty_update();
    int found, n;
    found = 0;
    bus.sw_dir = 4'b0001;
    wait_cycles(20);
    bus.sw_speed = 4'b1000;
    for (int i = 0; i < 400 && found == 0; i++) begin
      tick();
      if (bus.ena === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL ramp_start: got no enable within 400 cycles expected one");
    end
    for (int p = 0; p < 4; p++) begin
      n = 0;
      for (int j = 0; j < PERIOD; j++) begin
        if (p != 0 || j != 0) tick();
        if (bus.ena === 1'b1 && bus.enb === 1'b1) n++;
      end
      checks++;
      if (n !== model_ramp(p, model_pct(4'b1000))) begin
        errors++;
        $display("FAIL ramp_period%0d: got %0d enabled cycles expected %0d",
                 p, n, model_ramp(p, 100));
      end
    end
  endtask

  task automatic test_async_reset();
    wait_cycles(37);
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.ena, bus.enb, bridge_now(), bus.fault} !== 7'd0 ||
        {bus.dig0, bus.dig1, bus.dig2, bus.dig3} !== {4'd15, 4'd0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL async_reset: got en/in/fault=%b dig=%0d %0d %0d %0d expected 0000000 15 0 0 0",
               {bus.ena, bus.enb, bridge_now(), bus.fault}, bus.dig0, bus.dig1, bus.dig2, bus.dig3);
    end
    wait_cycles(3);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] spd, dr;
    int pct, d, highs, bad, exp_highs;
    for (int it = 0; it < 10; it++) begin
      spd = 4'($urandom_range(0, 15));
      dr  = 4'($urandom_range(0, 15));
      bus.sw_speed = spd;
      bus.sw_dir   = dr;
      pct = model_pct(spd);
      d   = model_dir(dr);
      wait_cycles(520);
      if (d != 0 && pct != 0) exp_highs = PERIOD * pct / 100;
      else                    exp_highs = 0;
      measure(PERIOD, (d != 0 && pct != 0) ? model_bridge(d) : 4'b0000,
              model_dig0(d), model_digits(pct), highs, bad);
      checks++;
      if (highs !== exp_highs || bad !== 0) begin
        errors++;
        $display("FAIL random%0d spd=%b dir=%b: got highs=%0d bad=%0d expected highs=%0d bad=0",
                 it, spd, dr, highs, bad, exp_highs);
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    resetn       = 1'b0;
    bus.sw_speed = 4'b0000;
    bus.sw_dir   = 4'b0000;
    bus.comp_a   = 1'b0;
    bus.comp_b   = 1'b0;
    #2;
    test_reset();
    test_run_forward();
    test_priority_glitch();
    test_dead_time();
    test_fault_hold_speed();
    test_fault_cooldown();
    test_duty_update();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_pwm_ctrl.md
MOTOR_PWM_CTRL -- requirements
Module: motor_pwm_ctrl

Interface
REQ-001 Parameter PWM_PERIOD, default 1000; clock cycles per PWM period, SHALL be a multiple of 4.
REQ-002 Parameter DEB_CYCLES, default 65536; consecutive stable synchronized cycles needed to accept a switch change.
REQ-003 Parameter DEAD_CYCLES, default 5000; H-bridge off time on a direction change.
REQ-004 Parameter COOLDOWN_CYCLES, default 10000000; minimum time spent in FAULT.
REQ-005 clock  in  1  sole clock; all state on rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 sw_speed  in  4  raw speed switches; bit0=25%, bit1=50%, bit2=75%, bit3=100%.
REQ-008 sw_dir  in  4  raw direction switches; bit0=forward, bit1=backward, bit2=left, bit3=right.
REQ-009 comp_a, comp_b  in  1 each  asynchronous overcurrent comparators, active-high.
REQ-010 ena, enb  out  1 each  PWM enables, motor A and motor B.
REQ-011 in1, in2, in3, in4  out  1 each  H-bridge inputs (in1/in2 motor A, in3/in4 motor B).
REQ-012 fault  out  1  high while in FAULT.
REQ-013 dig0, dig1, dig2, dig3  out  4 each  display codes: dig0 direction, dig3..dig1 duty percent digits.

Function
REQ-014 Each switch and comparator SHALL pass a 2-flop synchronizer; switches SHALL be debounced, taking the new value after DEB_CYCLES stable cycles (latency 2+DEB_CYCLES).
REQ-015 Target speed SHALL be priority-encoded from debounced sw_speed, bit0 highest: 25/50/75/100%; none set = 0%.
REQ-016 Direction SHALL be priority-encoded, bit3 highest: right > left > backward > forward; none set = stop.
REQ-017 Bridge mapping: forward A=10,B=10; backward A=01,B=01; left A=01,B=10; right A=10,B=01; stop all 0 (pairs are in1in2, in3in4).
REQ-018 PWM counter SHALL run 0..PWM_PERIOD-1 and wrap; ena=enb=(counter < duty_cycles) in RUN, else 0.
REQ-019 duty_cycles SHALL equal (PWM_PERIOD/4)*k, k=0..4, and SHALL update only when the counter wraps to 0.
REQ-020 FSM states: IDLE, RUN, DEAD, FAULT.
REQ-021 IDLE -> RUN when direction != stop and target speed != 0; RUN -> IDLE when either becomes stop/0.
REQ-022 RUN -> DEAD on a change of debounced direction code; DEAD forces ena/enb/in1..in4 to 0 for DEAD_CYCLES, then enters RUN with the new direction (IDLE if stop).
REQ-023 A synchronized comp_a or comp_b high in any state SHALL enter FAULT the next cycle; FAULT has priority over all other transitions.
REQ-024 FAULT: all bridge outputs 0, fault=1, dig0..dig3=11; exit to IDLE only after COOLDOWN_CYCLES AND comparators low AND target speed 0; a comparator re-assertion restarts the cooldown.
REQ-025 Outside FAULT: dig0 = 11 forward, 10 backward, 12 left, 13 right, 15 stop; dig3..dig1 = 0,2,5 / 0,5,0 / 0,7,5 / 1,0,0 / 0,0,0 for target speed.

Reset
REQ-026 resetn low SHALL asynchronously set state IDLE, counters 0, debounced values 0, ena=enb=in1..in4=fault=0, dig0=15, dig1..dig3=0.
REQ-027 Reset mid-PWM-period or mid-DEAD SHALL take effect without completing the period or dead time.

Configuration
REQ-028 Macro SOFT_START_EN defined: duty_cycles SHALL step up by PWM_PERIOD/4 per period wrap toward target; decreases apply at the next wrap.
REQ-029 SOFT_START_EN undefined: duty_cycles SHALL take the target at the next wrap; the ramp logic SHALL be absent.

Verification (PWM_PERIOD=100, DEB_CYCLES=4, DEAD_CYCLES=8, COOLDOWN_CYCLES=50)
REQ-030 Reset release, sw_dir=0001, sw_speed=0010 -> after debounce, RUN; in1..in4=1010; ena high 50 of every 100 cycles; dig0=11, dig3..1=0,5,0.
REQ-031 Both sw_speed bits 0 and 3 set -> 25% duty, digits 0,2,5; 3-cycle switch glitch -> no change in outputs.
REQ-032 RUN forward, switch to sw_dir=1000 -> ena/enb/in1..in4 all 0 for exactly 8 cycles, then in1..in4=1001.
REQ-033 comp_b pulse 1 cycle during RUN -> fault=1 within 3 cycles, dig0..3=11; speed held 0 -> IDLE after 50 cycles; speed held nonzero -> stays FAULT.
REQ-034 With SOFT_START_EN, 0% -> 100% -> duty 25,50,75,100 on four successive periods; without, 100 on the first wrap.
REQ-035 resetn pulse mid-period in RUN -> all outputs at reset values within the same cycle, asynchronously.
